axi_read_arbiter: RTL

- Read-channel controller for the 2-master / 2-slave AXI interconnect.
- Arbitrates AR requests from M0 and M1 round-robin.
- Decodes the granted address against the slave0/slave1 ranges and holds the route until the read burst's last beat is accepted.
- Answers unmapped addresses with a DECERR response. The interconnect muxes steer AR/R channels from master_sel/slave_sel and the route-enable outputs.

---
 rtl/axi_read_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Read-channel controller for a 2-master / 2-slave AXI interconnect: round-robin
// AR arbitration, address decode, route hold until RLAST, DECERR for unmapped reads.
module axi_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          RESET_PRIO = 1'b0
) (
    input  logic                  G_clk,
    input  logic                  G_reset,
    input  logic                  M0_ARVALID,
    input  logic [ADDR_WIDTH-1:0] M0_ARADDR,
    input  logic                  M0_RREADY,
    input  logic                  M1_ARVALID,
    input  logic [ADDR_WIDTH-1:0] M1_ARADDR,
    input  logic                  M1_RREADY,
    input  logic                  S0_ARREADY,
    input  logic                  S0_RVALID,
    input  logic                  S0_RLAST,
    input  logic                  S1_ARREADY,
    input  logic                  S1_RVALID,
    input  logic                  S1_RLAST,
    input  logic [ADDR_WIDTH-1:0] slave0_addr1,
    input  logic [ADDR_WIDTH-1:0] slave0_addr2,
    input  logic [ADDR_WIDTH-1:0] slave1_addr1,
    input  logic [ADDR_WIDTH-1:0] slave1_addr2,
    output logic                  master_sel,
    output logic                  slave_sel,
    output logic                  ar_route_en,
    output logic                  r_route_en,
    output logic                  err_arready,
    output logic                  err_rvalid,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ERR_A = 3'd3,
        ERR_R = 3'd4
    } state_t;

    state_t state_q;
    logic   ptr_q;
    logic   master_sel_q;
    logic   slave_sel_q;
    logic   ar_route_en_q;
    logic   r_route_en_q;
    logic   err_arready_q;
    logic   err_rvalid_q;
    logic   busy_q;

    logic                  any_req;
    logic                  win_d;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  hit0;
    logic                  hit1;

    // Granted-master / selected-slave views of the handshake signals.
    logic g_arvalid;
    logic g_rready;
    logic s_arready;
    logic s_rvalid;
    logic s_rlast;

    always_comb begin
        any_req  = M0_ARVALID | M1_ARVALID;
        win_d    = (M0_ARVALID & M1_ARVALID) ? ptr_q : M1_ARVALID;
        win_addr = win_d ? M1_ARADDR : M0_ARADDR;
        // An inverted range (addr1 > addr2) can never satisfy both bounds.
        hit0     = (win_addr >= slave0_addr1) && (win_addr <= slave0_addr2);
        hit1     = (win_addr >= slave1_addr1) && (win_addr <= slave1_addr2);

        g_arvalid = master_sel_q ? M1_ARVALID : M0_ARVALID;
        g_rready  = master_sel_q ? M1_RREADY  : M0_RREADY;
        s_arready = slave_sel_q  ? S1_ARREADY : S0_ARREADY;
        s_rvalid  = slave_sel_q  ? S1_RVALID  : S0_RVALID;
        s_rlast   = slave_sel_q  ? S1_RLAST   : S0_RLAST;
    end

    always_ff @(posedge G_clk) begin
        if (G_reset) begin
            state_q       <= IDLE;
            ptr_q         <= RESET_PRIO;
            master_sel_q  <= 1'b0;
            slave_sel_q   <= 1'b0;
            ar_route_en_q <= 1'b0;
            r_route_en_q  <= 1'b0;
            err_arready_q <= 1'b0;
            err_rvalid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        master_sel_q <= win_d;
                        busy_q       <= 1'b1;
                        if (hit0 || hit1) begin
                            slave_sel_q   <= ~hit0;
                            ar_route_en_q <= 1'b1;
                            state_q       <= ADDR;
                        end else begin
                            slave_sel_q   <= 1'b0;
                            err_arready_q <= 1'b1;
                            state_q       <= ERR_A;
                        end
                    end
                end
                ADDR: begin
                    if (s_arready && g_arvalid) begin
                        ar_route_en_q <= 1'b0;
                        r_route_en_q  <= 1'b1;
                        state_q       <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && g_rready && s_rlast) begin
                        r_route_en_q <= 1'b0;
                        busy_q       <= 1'b0;
                        ptr_q        <= ~master_sel_q;
                        state_q      <= IDLE;
                    end
                end
                ERR_A: begin
                    err_arready_q <= 1'b0;
                    err_rvalid_q  <= 1'b1;
                    state_q       <= ERR_R;
                end
                ERR_R: begin
                    if (g_rready) begin
                        err_rvalid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        ptr_q        <= ~master_sel_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign master_sel  = master_sel_q;
    assign slave_sel   = slave_sel_q;
    assign ar_route_en = ar_route_en_q;
    assign r_route_en  = r_route_en_q;
    assign err_arready = err_arready_q;
    assign err_rvalid  = err_rvalid_q;
    assign busy        = busy_q;

endmodule
